// File: rtl/qspi_pkg.sv
// -----------------------------------------------------------------------------
// qspi_pkg
// Shared types and constants for the QSPI line-transfer arbiter.
//   state_t : arbiter FSM states (IDLE, ISSUE, XFER, GAP)
//   owner_t : which requester currently owns the controller
//   rr_t    : round-robin preference between I-fill and D-fill
//   line_addr_w() : width of a line address for a given PA / line size
// -----------------------------------------------------------------------------
package qspi_pkg;

    localparam int LINE_LENGTH_DEF = 4;
    localparam int PA_DEF          = 24;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        XFER,
        GAP
    } state_t;

    typedef enum logic [1:0] {
        OWN_I,
        OWN_D,
        OWN_WB
    } owner_t;

    typedef enum logic {
        RR_I,
        RR_D
    } rr_t;

    function automatic int line_addr_w(input int pa, input int line_length);
        return pa - $clog2(line_length);
    endfunction

endpackage

// File: rtl/qspi_arb_if.sv
// -----------------------------------------------------------------------------
// qspi_arb_if
// Command / strobe / config-register bus between the arbiter and the QSPI
// line-transfer controller. Nibble data lines are not part of this bus.
//   master : arbiter side  (drives command + register write, sees strobes)
//   slave  : controller side
// Parameter AW : line address width (PA - log2(LINE_LENGTH)).
// -----------------------------------------------------------------------------
interface qspi_arb_if
    import qspi_pkg::*;
#(
    parameter int AW = line_addr_w(PA_DEF, LINE_LENGTH_DEF)
);
    logic          q_req;
    logic          q_i_d;
    logic          q_mem;
    logic          q_write;
    logic [AW-1:0] q_paddr;
    logic          q_wstrobe_i;
    logic          q_wstrobe_d;
    logic          q_rstrobe_d;
    logic [3:0]    q_reg_addr;
    logic [7:0]    q_reg_data;
    logic          q_reg_write;

    modport master (
        output q_req, q_i_d, q_mem, q_write, q_paddr,
        output q_reg_addr, q_reg_data, q_reg_write,
        input  q_wstrobe_i, q_wstrobe_d, q_rstrobe_d
    );

    modport slave (
        input  q_req, q_i_d, q_mem, q_write, q_paddr,
        input  q_reg_addr, q_reg_data, q_reg_write,
        output q_wstrobe_i, q_wstrobe_d, q_rstrobe_d
    );
endinterface

// File: rtl/qspi_arb_pick.sv
// -----------------------------------------------------------------------------
// qspi_arb_pick
// Combinational requester selector.
//   wb_req_i has absolute priority and does not move the round-robin pointer.
//   Between i_req_i and d_req_i the side named by rr_i wins a tie; whichever
//   read side is granted, rr_next_o points at the other side.
// Ports:
//   i_req_i, d_req_i, wb_req_i : request levels
//   rr_i                       : current round-robin preference
//   grant_valid_o              : some requester is selected
//   owner_o                    : selected requester
//   rr_next_o                  : pointer value to store if the grant is taken
// -----------------------------------------------------------------------------
module qspi_arb_pick
    import qspi_pkg::*;
(
    input  logic   i_req_i,
    input  logic   d_req_i,
    input  logic   wb_req_i,
    input  rr_t    rr_i,
    output logic   grant_valid_o,
    output owner_t owner_o,
    output rr_t    rr_next_o
);

    // NOTE: every output gets a default before the if-chain so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    always_comb begin
        grant_valid_o = 1'b1;
        owner_o       = OWN_I;
        rr_next_o     = rr_i;
        if (wb_req_i) begin
            owner_o = OWN_WB;
        end else if (i_req_i && (!d_req_i || rr_i == RR_I)) begin
            owner_o   = OWN_I;
            rr_next_o = RR_D;
        end else if (d_req_i) begin
            owner_o   = OWN_D;
            rr_next_o = RR_I;
        end else begin
            grant_valid_o = 1'b0;
        end
    end

endmodule

// File: rtl/qspi_arb.sv
// -----------------------------------------------------------------------------
// qspi_arb
// Single-owner scheduler in front of the QSPI line-transfer controller.
// Grants one of I-fill / D-fill / writeback, holds the command stable for the
// whole burst, detects completion by counting the owner's nibble strobes
// (the controller has no ack), enforces GAP_CYCLES idle cycles after each
// burst, and defers config-register writes until the arbiter is idle.
//
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   i_req/i_mem/i_addr         : I-fill request (level, held until i_done)
//   d_req/d_mem/d_addr         : D-fill request
//   wb_req/wb_mem/wb_addr      : writeback request
//   i_done/d_done/wb_done      : one-cycle completion pulses
//   cfg_addr/cfg_data/cfg_write: config register write (pulse)
//   cfg_busy                   : a config write is pending
//   wp_err                     : sticky flash write-protect error (optional)
//   q                          : controller bus (qspi_arb_if.master)
//
// Optional build macro QSPI_ARB_FLASH_WP_EN: writebacks targeting flash
// (wb_mem=0) are never issued; they complete immediately with wb_done and set
// the sticky wp_err output.
// -----------------------------------------------------------------------------
module qspi_arb
    import qspi_pkg::*;
#(
    parameter int LINE_LENGTH  = LINE_LENGTH_DEF,
    parameter int PA           = PA_DEF,
    parameter int XFER_NIBBLES = 2 * LINE_LENGTH + 1,
    parameter int GAP_CYCLES   = 2,
    localparam int AW          = PA - $clog2(LINE_LENGTH)
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          i_req,
    input  logic          i_mem,
    input  logic [AW-1:0] i_addr,
    input  logic          d_req,
    input  logic          d_mem,
    input  logic [AW-1:0] d_addr,
    input  logic          wb_req,
    input  logic          wb_mem,
    input  logic [AW-1:0] wb_addr,

    output logic          i_done,
    output logic          d_done,
    output logic          wb_done,

    input  logic [3:0]    cfg_addr,
    input  logic [7:0]    cfg_data,
    input  logic          cfg_write,
    output logic          cfg_busy,
`ifdef QSPI_ARB_FLASH_WP_EN
    output logic          wp_err,
`endif
    qspi_arb_if.master    q
);

    localparam int CW = $clog2(XFER_NIBBLES + 1);
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    state_t        state_q;
    owner_t        owner_q;
    rr_t           rr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic [GW-1:0] gap_q;

    logic          q_req_q;
    logic          q_i_d_q;
    logic          q_mem_q;
    logic          q_write_q;
    logic [AW-1:0] q_paddr_q;

    logic          i_done_q;
    logic          d_done_q;
    logic          wb_done_q;

    logic          cfg_busy_q;
    logic [3:0]    cfg_addr_q;
    logic [7:0]    cfg_data_q;
    logic [3:0]    q_reg_addr_q;
    logic [7:0]    q_reg_data_q;
    logic          q_reg_write_q;
`ifdef QSPI_ARB_FLASH_WP_EN
    logic          wp_err_q;
`endif

    logic          grant_valid;
    owner_t        grant_owner;
    rr_t           rr_next;
    logic          owner_strobe;

    qspi_arb_pick u_pick (
        .i_req_i       (i_req),
        .d_req_i       (d_req),
        .wb_req_i      (wb_req),
        .rr_i          (rr_q),
        .grant_valid_o (grant_valid),
        .owner_o       (grant_owner),
        .rr_next_o     (rr_next)
    );

    // Only the strobe belonging to the current owner advances the count.
    always_comb begin
        owner_strobe = 1'b0;
        case (owner_q)
            OWN_I:   owner_strobe = q.q_wstrobe_i;
            OWN_D:   owner_strobe = q.q_wstrobe_d;
            OWN_WB:  owner_strobe = q.q_rstrobe_d;
            default: owner_strobe = 1'b0;
        endcase
    end

    assign count_d = count_q + CW'(1);

    // NOTE: all state and registered outputs use non-blocking assignments so
    // every right-hand side reads the pre-edge value of the registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            owner_q       <= OWN_I;
            rr_q          <= RR_I;
            count_q       <= '0;
            gap_q         <= '0;
            q_req_q       <= 1'b0;
            q_i_d_q       <= 1'b0;
            q_mem_q       <= 1'b0;
            q_write_q     <= 1'b0;
            q_paddr_q     <= '0;
            i_done_q      <= 1'b0;
            d_done_q      <= 1'b0;
            wb_done_q     <= 1'b0;
            cfg_busy_q    <= 1'b0;
            cfg_addr_q    <= '0;
            cfg_data_q    <= '0;
            q_reg_addr_q  <= '0;
            q_reg_data_q  <= '0;
            q_reg_write_q <= 1'b0;
`ifdef QSPI_ARB_FLASH_WP_EN
            wp_err_q      <= 1'b0;
`endif
        end else begin
            i_done_q      <= 1'b0;
            d_done_q      <= 1'b0;
            wb_done_q     <= 1'b0;
            q_reg_write_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (cfg_busy_q) begin
                        // Forwarding a config write occupies this IDLE cycle.
                        q_reg_write_q <= 1'b1;
                        q_reg_addr_q  <= cfg_addr_q;
                        q_reg_data_q  <= cfg_data_q;
`ifdef QSPI_ARB_FLASH_WP_EN
                    end else if (grant_valid && grant_owner == OWN_WB && !wb_mem) begin
                        // Refused flash write: complete at once. A one-cycle
                        // GAP keeps the still-asserted wb_req from completing
                        // a second time before the requester sees wb_done.
                        wb_done_q <= 1'b1;
                        wp_err_q  <= 1'b1;
                        gap_q     <= '0;
                        state_q   <= GAP;
`endif
                    end else if (grant_valid) begin
                        owner_q <= grant_owner;
                        rr_q    <= rr_next;
                        q_req_q <= 1'b1;
                        case (grant_owner)
                            OWN_WB: begin
                                q_mem_q   <= wb_mem;
                                q_paddr_q <= wb_addr;
                                q_write_q <= 1'b1;
                                q_i_d_q   <= 1'b0;
                            end
                            OWN_D: begin
                                q_mem_q   <= d_mem;
                                q_paddr_q <= d_addr;
                                q_write_q <= 1'b0;
                                q_i_d_q   <= 1'b0;
                            end
                            default: begin
                                q_mem_q   <= i_mem;
                                q_paddr_q <= i_addr;
                                q_write_q <= 1'b0;
                                q_i_d_q   <= 1'b1;
                            end
                        endcase
                        state_q <= ISSUE;
                    end
                end

                ISSUE: begin
                    // The first owner strobe doubles as the controller's
                    // acceptance of the command.
                    if (owner_strobe) begin
                        q_req_q <= 1'b0;
                        count_q <= CW'(1);
                        state_q <= XFER;
                    end
                end

                XFER: begin
                    if (owner_strobe) begin
                        count_q <= count_d;
                        if (count_d == CW'(XFER_NIBBLES)) begin
                            case (owner_q)
                                OWN_I:   i_done_q  <= 1'b1;
                                OWN_D:   d_done_q  <= 1'b1;
                                default: wb_done_q <= 1'b1;
                            endcase
                            gap_q   <= GW'(GAP_CYCLES);
                            state_q <= GAP;
                        end
                    end
                end

                GAP: begin
                    if (gap_q <= GW'(1)) begin
                        gap_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        gap_q <= gap_q - GW'(1);
                    end
                end

                default: state_q <= IDLE;
            endcase

            // A new write always re-arms the latch, even in the cycle the
            // previous one is being forwarded; the last write wins.
            if (cfg_write) begin
                cfg_busy_q <= 1'b1;
                cfg_addr_q <= cfg_addr;
                cfg_data_q <= cfg_data;
            end else if (state_q == IDLE && cfg_busy_q) begin
                cfg_busy_q <= 1'b0;
            end
        end
    end

    assign q.q_req       = q_req_q;
    assign q.q_i_d       = q_i_d_q;
    assign q.q_mem       = q_mem_q;
    assign q.q_write     = q_write_q;
    assign q.q_paddr     = q_paddr_q;
    assign q.q_reg_addr  = q_reg_addr_q;
    assign q.q_reg_data  = q_reg_data_q;
    assign q.q_reg_write = q_reg_write_q;

    assign i_done   = i_done_q;
    assign d_done   = d_done_q;
    assign wb_done  = wb_done_q;
    assign cfg_busy = cfg_busy_q;
`ifdef QSPI_ARB_FLASH_WP_EN
    assign wp_err   = wp_err_q;
`endif

endmodule

// File: tb/tb_qspi_arb.sv
// -----------------------------------------------------------------------------
// tb_qspi_arb
// Directed testbench for qspi_arb with default parameters (LINE_LENGTH=4,
// PA=24, 9 strobes per burst, 2 gap cycles). Inputs are driven and outputs
// sampled on the falling clock edge; the DUT registers on the rising edge.
// Build macro QSPI_ARB_FLASH_WP_EN selects the write-protect scenario.
// -----------------------------------------------------------------------------
module tb_qspi_arb;
    import qspi_pkg::*;

    localparam int AW = 22;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_req, i_mem, d_req, d_mem, wb_req, wb_mem;
    logic [AW-1:0] i_addr, d_addr, wb_addr;
    logic          i_done, d_done, wb_done;
    logic [3:0]    cfg_addr;
    logic [7:0]    cfg_data;
    logic          cfg_write, cfg_busy;
`ifdef QSPI_ARB_FLASH_WP_EN
    logic          wp_err;
`endif

    int total = 0;
    int bad   = 0;

    qspi_arb_if #(.AW(AW)) q_if ();

    qspi_arb dut (
        .clk       (clk),
        .reset     (reset),
        .i_req     (i_req),
        .i_mem     (i_mem),
        .i_addr    (i_addr),
        .d_req     (d_req),
        .d_mem     (d_mem),
        .d_addr    (d_addr),
        .wb_req    (wb_req),
        .wb_mem    (wb_mem),
        .wb_addr   (wb_addr),
        .i_done    (i_done),
        .d_done    (d_done),
        .wb_done   (wb_done),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .cfg_write (cfg_write),
        .cfg_busy  (cfg_busy),
`ifdef QSPI_ARB_FLASH_WP_EN
        .wp_err    (wp_err),
`endif
        .q         (q_if)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        i_req = 1'b0; i_mem = 1'b0; i_addr = '0;
        d_req = 1'b0; d_mem = 1'b0; d_addr = '0;
        wb_req = 1'b0; wb_mem = 1'b0; wb_addr = '0;
        cfg_addr = '0; cfg_data = '0; cfg_write = 1'b0;
        q_if.q_wstrobe_i = 1'b0; q_if.q_wstrobe_d = 1'b0; q_if.q_rstrobe_d = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Advance until q_req is seen; n = cycles taken, -1 if never within budget.
    task automatic wait_req(output int n);
        n = -1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (q_if.q_req === 1'b1) begin
                n = c;
                break;
            end
        end
    endtask

    task automatic set_strobes(input owner_t own, input logic on);
        q_if.q_wstrobe_i = (own == OWN_I)  ? on : ~on;
        q_if.q_wstrobe_d = (own == OWN_D)  ? on : ~on;
        q_if.q_rstrobe_d = (own == OWN_WB) ? on : ~on;
    endtask

    // Drives n owner strobes, each followed by a cycle in which only the two
    // non-owner strobes are active. done_step = index of the owner strobe
    // right after which the owner's done appeared (0 = never); stray counts
    // any other done pulse observed.
    task automatic strobe_burst(input owner_t own, input int n,
                                output int done_step, output int stray);
        logic own_done, other_done;
        done_step = 0;
        stray     = 0;
        for (int k = 1; k <= n; k++) begin
            set_strobes(own, 1'b1);
            tick();
            own_done   = (own == OWN_I) ? i_done : (own == OWN_D) ? d_done : wb_done;
            other_done = (i_done | d_done | wb_done) & ~own_done;
            if (own_done === 1'b1) begin
                if (done_step == 0) done_step = k;
                else stray++;
            end
            if (other_done === 1'b1) stray++;
            set_strobes(own, 1'b0);
            tick();
            if ((i_done | d_done | wb_done) !== 1'b0) stray++;
        end
        q_if.q_wstrobe_i = 1'b0; q_if.q_wstrobe_d = 1'b0; q_if.q_rstrobe_d = 1'b0;
    endtask

    task automatic test_reset();
        logic [AW+8:0] outs;
        do_reset();
        outs = {q_if.q_req, q_if.q_i_d, q_if.q_mem, q_if.q_write, q_if.q_paddr,
                i_done, d_done, wb_done, cfg_busy, q_if.q_reg_write};
        total++; if (outs !== '0) begin bad++; $display("FAIL reset_outputs: got=%0h want=0", outs); end
`ifdef QSPI_ARB_FLASH_WP_EN
        total++; if (wp_err !== 1'b0) begin bad++; $display("FAIL reset_wp_err: got=%0b want=0", wp_err); end
`endif
    endtask

    task automatic test_single_ifill();
        int n, ds, st;
        do_reset();
        i_req = 1'b1; i_mem = 1'b0; i_addr = 22'h12345;
        wait_req(n);
        total++; if (n !== 1) begin bad++; $display("FAIL single_latency: got=%0d want=1", n); end
        total++; if ({q_if.q_i_d, q_if.q_write, q_if.q_mem} !== 3'b100) begin
            bad++; $display("FAIL single_cmd: got=%b want=100", {q_if.q_i_d, q_if.q_write, q_if.q_mem}); end
        total++; if (q_if.q_paddr !== 22'h12345) begin bad++; $display("FAIL single_paddr: got=%0h want=12345", q_if.q_paddr); end
        tick(); tick();
        total++; if (q_if.q_req !== 1'b1) begin bad++; $display("FAIL single_req_hold: got=%0b want=1", q_if.q_req); end
        strobe_burst(OWN_I, 1, ds, st);
        total++; if (q_if.q_req !== 1'b0 || ds !== 0) begin
            bad++; $display("FAIL single_first_strobe: got req=%0b done_step=%0d want req=0 done_step=0", q_if.q_req, ds); end
        strobe_burst(OWN_I, 8, ds, st);
        total++; if (ds !== 8 || st !== 0) begin
            bad++; $display("FAIL single_done: got step=%0d stray=%0d want step=8 stray=0", ds, st); end
        // i_req is still held: the re-request must wait out the gap.
        wait_req(n);
        total++; if (n !== 2) begin bad++; $display("FAIL single_gap: got=%0d want=2", n); end
        // Dropping the request after the grant must not abandon the burst.
        i_req = 1'b0;
        strobe_burst(OWN_I, 9, ds, st);
        total++; if (ds !== 9 || st !== 0) begin
            bad++; $display("FAIL single_drop_after_grant: got step=%0d stray=%0d want step=9 stray=0", ds, st); end
        repeat (4) tick();
        total++; if (q_if.q_req !== 1'b0) begin bad++; $display("FAIL single_no_reissue: got=%0b want=0", q_if.q_req); end
    endtask

    task automatic test_back_to_back();
        int n, ds, st;
        logic exp_id;
        do_reset();
        i_req = 1'b1; i_addr = 22'h0AAAA;
        d_req = 1'b1; d_addr = 22'h15555; d_mem = 1'b1;
        for (int b = 0; b < 4; b++) begin
            exp_id = (b % 2 == 0);
            wait_req(n);
            total++; if (n !== ((b == 0) ? 1 : 2)) begin bad++; $display("FAIL rr_latency_%0d: got=%0d want=%0d", b, n, (b == 0) ? 1 : 2); end
            total++; if (q_if.q_i_d !== exp_id) begin bad++; $display("FAIL rr_owner_%0d: got i_d=%0b want=%0b", b, q_if.q_i_d, exp_id); end
            total++; if (q_if.q_paddr !== (exp_id ? 22'h0AAAA : 22'h15555)) begin
                bad++; $display("FAIL rr_paddr_%0d: got=%0h want=%0h", b, q_if.q_paddr, exp_id ? 22'h0AAAA : 22'h15555); end
            strobe_burst(exp_id ? OWN_I : OWN_D, 9, ds, st);
            total++; if (ds !== 9 || st !== 0) begin
                bad++; $display("FAIL rr_done_%0d: got step=%0d stray=%0d want step=9 stray=0", b, ds, st); end
        end
        i_req = 1'b0; d_req = 1'b0;
        repeat (3) tick();
        total++; if (q_if.q_req !== 1'b0) begin bad++; $display("FAIL rr_quiet: got=%0b want=0", q_if.q_req); end
    endtask

    task automatic test_wb_priority();
        int n, ds, st;
        do_reset();
        wb_req = 1'b1; wb_mem = 1'b1; wb_addr = 22'h3ABCD;
        i_req = 1'b1; i_addr = 22'h00111;
        d_req = 1'b1; d_addr = 22'h00222;
        wait_req(n);
        total++; if (n !== 1) begin bad++; $display("FAIL wb_latency: got=%0d want=1", n); end
        total++; if ({q_if.q_write, q_if.q_i_d, q_if.q_mem} !== 3'b101 || q_if.q_paddr !== 22'h3ABCD) begin
            bad++; $display("FAIL wb_cmd: got=%b/%0h want=101/3abcd", {q_if.q_write, q_if.q_i_d, q_if.q_mem}, q_if.q_paddr); end
        strobe_burst(OWN_WB, 9, ds, st);
        total++; if (ds !== 9 || st !== 0) begin
            bad++; $display("FAIL wb_done: got step=%0d stray=%0d want step=9 stray=0", ds, st); end
        wb_req = 1'b0;
        wait_req(n);
        total++; if (n !== 2 || {q_if.q_write, q_if.q_i_d} !== 2'b01) begin
            bad++; $display("FAIL wb_then_i: got n=%0d w/id=%b want n=2 w/id=01", n, {q_if.q_write, q_if.q_i_d}); end
        strobe_burst(OWN_I, 9, ds, st);
        total++; if (ds !== 9 || st !== 0) begin
            bad++; $display("FAIL wb_i_done: got step=%0d stray=%0d want step=9 stray=0", ds, st); end
        i_req = 1'b0;
        wait_req(n);
        total++; if (n !== 2 || {q_if.q_write, q_if.q_i_d} !== 2'b00 || q_if.q_paddr !== 22'h00222) begin
            bad++; $display("FAIL wb_then_d: got n=%0d w/id=%b addr=%0h want n=2 w/id=00 addr=222", n, {q_if.q_write, q_if.q_i_d}, q_if.q_paddr); end
        strobe_burst(OWN_D, 9, ds, st);
        total++; if (ds !== 9 || st !== 0) begin
            bad++; $display("FAIL wb_d_done: got step=%0d stray=%0d want step=9 stray=0", ds, st); end
        d_req = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_cfg_defer();
        int n, ds, st;
        do_reset();
        i_req = 1'b1; i_addr = 22'h00042;
        wait_req(n);
        strobe_burst(OWN_I, 4, ds, st);
        total++; if (ds !== 0) begin bad++; $display("FAIL cfg_early_done: got step=%0d want 0", ds); end
        cfg_write = 1'b1; cfg_addr = 4'd2; cfg_data = 8'h11;
        tick();
        cfg_addr = 4'd1; cfg_data = 8'h86;
        tick();
        cfg_write = 1'b0;
        total++; if (cfg_busy !== 1'b1 || q_if.q_reg_write !== 1'b0) begin
            bad++; $display("FAIL cfg_busy_mid_xfer: got busy=%0b wr=%0b want busy=1 wr=0", cfg_busy, q_if.q_reg_write); end
        i_req = 1'b0;
        d_req = 1'b1; d_addr = 22'h00777;
        strobe_burst(OWN_I, 5, ds, st);
        total++; if (ds !== 5 || st !== 0) begin
            bad++; $display("FAIL cfg_burst_done: got step=%0d stray=%0d want step=5 stray=0", ds, st); end
        total++; if (cfg_busy !== 1'b1 || q_if.q_reg_write !== 1'b0) begin
            bad++; $display("FAIL cfg_held_in_gap: got busy=%0b wr=%0b want busy=1 wr=0", cfg_busy, q_if.q_reg_write); end
        tick();
        tick();
        total++; if ({q_if.q_reg_write, q_if.q_reg_addr, q_if.q_reg_data, cfg_busy, q_if.q_req} !== {1'b1, 4'd1, 8'h86, 1'b0, 1'b0}) begin
            bad++; $display("FAIL cfg_forward: got wr=%0b a=%0h d=%0h busy=%0b req=%0b want wr=1 a=1 d=86 busy=0 req=0",
                            q_if.q_reg_write, q_if.q_reg_addr, q_if.q_reg_data, cfg_busy, q_if.q_req); end
        tick();
        total++; if (q_if.q_reg_write !== 1'b0 || q_if.q_req !== 1'b1 || q_if.q_i_d !== 1'b0) begin
            bad++; $display("FAIL cfg_then_issue: got wr=%0b req=%0b id=%0b want wr=0 req=1 id=0", q_if.q_reg_write, q_if.q_req, q_if.q_i_d); end
        d_req = 1'b0;
        strobe_burst(OWN_D, 9, ds, st);
        total++; if (ds !== 9 || st !== 0) begin
            bad++; $display("FAIL cfg_d_done: got step=%0d stray=%0d want step=9 stray=0", ds, st); end
        repeat (3) tick();
    endtask

    task automatic test_reset_mid_burst();
        int n, ds, st;
        logic [AW+8:0] outs;
        do_reset();
        d_req = 1'b1; d_mem = 1'b1; d_addr = 22'h2F00F;
        wait_req(n);
        cfg_write = 1'b1; cfg_addr = 4'd3; cfg_data = 8'h5A;
        tick();
        cfg_write = 1'b0;
        strobe_burst(OWN_D, 4, ds, st);
        total++; if (ds !== 0 || cfg_busy !== 1'b1) begin
            bad++; $display("FAIL rst_pre: got step=%0d busy=%0b want step=0 busy=1", ds, cfg_busy); end
        reset = 1'b1;
        d_req = 1'b0;
        tick();
        outs = {q_if.q_req, q_if.q_i_d, q_if.q_mem, q_if.q_write, q_if.q_paddr,
                i_done, d_done, wb_done, cfg_busy, q_if.q_reg_write};
        total++; if (outs !== '0) begin bad++; $display("FAIL rst_mid_outputs: got=%0h want=0", outs); end
        tick();
        total++; if (d_done !== 1'b0) begin bad++; $display("FAIL rst_no_done: got=%0b want=0", d_done); end
        reset = 1'b0;
        d_req = 1'b1; d_mem = 1'b0; d_addr = 22'h00123;
        wait_req(n);
        total++; if (n !== 1 || q_if.q_paddr !== 22'h00123) begin
            bad++; $display("FAIL rst_fresh_issue: got n=%0d addr=%0h want n=1 addr=123", n, q_if.q_paddr); end
        d_req = 1'b0;
        strobe_burst(OWN_D, 9, ds, st);
        total++; if (ds !== 9 || st !== 0) begin
            bad++; $display("FAIL rst_fresh_done: got step=%0d stray=%0d want step=9 stray=0", ds, st); end
        repeat (3) tick();
    endtask

`ifdef QSPI_ARB_FLASH_WP_EN
    task automatic test_flash_wp();
        int n, ds, st;
        do_reset();
        wb_req = 1'b1; wb_mem = 1'b0; wb_addr = 22'h01000;
        tick();
        total++; if ({q_if.q_req, wb_done, wp_err} !== 3'b011) begin
            bad++; $display("FAIL wp_refuse: got req/done/err=%b want 011", {q_if.q_req, wb_done, wp_err}); end
        wb_req = 1'b0;
        tick();
        total++; if ({q_if.q_req, wb_done, wp_err} !== 3'b001) begin
            bad++; $display("FAIL wp_sticky: got req/done/err=%b want 001", {q_if.q_req, wb_done, wp_err}); end
        wb_req = 1'b1; wb_mem = 1'b1; wb_addr = 22'h02000;
        wait_req(n);
        total++; if (n !== 1 || q_if.q_write !== 1'b1 || q_if.q_mem !== 1'b1) begin
            bad++; $display("FAIL wp_psram_issue: got n=%0d w=%0b m=%0b want n=1 w=1 m=1", n, q_if.q_write, q_if.q_mem); end
        wb_req = 1'b0;
        strobe_burst(OWN_WB, 9, ds, st);
        total++; if (ds !== 9 || st !== 0 || wp_err !== 1'b1) begin
            bad++; $display("FAIL wp_psram_done: got step=%0d stray=%0d err=%0b want 9/0/1", ds, st, wp_err); end
        repeat (3) tick();
    endtask
`else
    task automatic test_flash_wb();
        int n, ds, st;
        do_reset();
        wb_req = 1'b1; wb_mem = 1'b0; wb_addr = 22'h01000;
        wait_req(n);
        total++; if (n !== 1 || q_if.q_write !== 1'b1 || q_if.q_mem !== 1'b0) begin
            bad++; $display("FAIL flash_wb_issue: got n=%0d w=%0b m=%0b want n=1 w=1 m=0", n, q_if.q_write, q_if.q_mem); end
        wb_req = 1'b0;
        strobe_burst(OWN_WB, 9, ds, st);
        total++; if (ds !== 9 || st !== 0) begin
            bad++; $display("FAIL flash_wb_done: got step=%0d stray=%0d want step=9 stray=0", ds, st); end
        repeat (3) tick();
    endtask
`endif

    initial begin
        test_reset();
        test_single_ifill();
        test_back_to_back();
        test_wb_priority();
        test_cfg_defer();
        test_reset_mid_burst();
`ifdef QSPI_ARB_FLASH_WP_EN
        test_flash_wp();
`else
        test_flash_wb();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
